// File: rtl/gpif2_pkg.sv
// Shared FSM state encoding and SL_AD thread codes for the GPIF-II master scheduler.
package gpif2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_BURST,
    ST_RD_DRAIN,
    ST_TURN,
    ST_WR_BURST
  } state_t;

  localparam logic [1:0] AD_U2F = 2'b11;
  localparam logic [1:0] AD_F2U = 2'b00;

endpackage

// File: rtl/gpif2_rd_pipe.sv
// Read return pipe: U2F_VLD pulses LAT_RD cycles after each SL_RD_N-low cycle, no backpressure.
// The FX3 drives the word in that same cycle, so U2F_DAT is taken straight from SL_DT_I.
module gpif2_rd_pipe #(
  parameter int WIDTH_DT = 32,
  parameter int LAT_RD   = 2
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                rd_issue,
  input  logic [WIDTH_DT-1:0] dt_i,
  output logic [WIDTH_DT-1:0] u2f_dat,
  output logic                u2f_vld
);

  logic [LAT_RD-1:0] vld_sr;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= rd_issue;
      for (int i = 1; i < LAT_RD; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  assign u2f_vld = vld_sr[LAT_RD-1];
  assign u2f_dat = u2f_vld ? dt_i : '0;

endmodule

// File: rtl/gpif2mst_sched.sv
// GPIF-II master burst scheduler: round-robin read/write bursts with drain and turnaround gaps.
// Strobes are combinational from state and flags; F2U uses valid/ready, U2F is gated by U2F_ROOM.
module gpif2mst_sched
  import gpif2_pkg::*;
#(
  parameter int WIDTH_DT  = 32,
  parameter int BURST_MAX = 16,
  parameter int LAT_RD    = 2,
  parameter int TURN      = 2
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                ENABLE,
  output logic                SL_CS_N,
  output logic [1:0]          SL_AD,
  output logic                SL_RD_N,
  output logic                SL_OE_N,
  output logic                SL_WR_N,
  output logic                SL_PKTEND_N,
  input  logic [WIDTH_DT-1:0] SL_DT_I,
  output logic [WIDTH_DT-1:0] SL_DT_O,
  output logic                SL_DT_T,
  input  logic                SL_FLAGA,
  input  logic                SL_FLAGC,
  output logic [WIDTH_DT-1:0] U2F_DAT,
  output logic                U2F_VLD,
  input  logic [15:0]         U2F_ROOM,
  input  logic [WIDTH_DT-1:0] F2U_DAT,
  input  logic                F2U_VLD,
  input  logic                F2U_LAST,
  output logic                F2U_RDY,
  output logic                BUSY
);

  localparam int CW   = $clog2(BURST_MAX + 1);
  localparam int TMAX = (LAT_RD > TURN) ? LAT_RD : TURN;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [15:0]   ROOM_MIN  = 16'(BURST_MAX + LAT_RD);
  localparam logic [CW-1:0] CNT_MAX   = CW'(BURST_MAX);
  localparam logic [TW-1:0] DRAIN_END = TW'(LAT_RD - 1);
  localparam logic [TW-1:0] TURN_END  = TW'(TURN - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [TW-1:0] tmr, tmr_nxt, tmr_inc;
  logic [1:0]    ad_q, ad_nxt;
  logic          prio_rd, prio_rd_nxt;
  logic          rd_el, wr_el, cnt_ok, rd_issue;

  // Room must cover a full burst plus words still in flight in the read pipe.
  assign rd_el   = ENABLE & SL_FLAGC & (U2F_ROOM >= ROOM_MIN);
  assign wr_el   = ENABLE & SL_FLAGA & F2U_VLD;
  assign cnt_ok  = cnt < CNT_MAX;
  assign cnt_inc = cnt + CW'(1);
  assign tmr_inc = tmr + TW'(1);

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tmr     <= '0;
      ad_q    <= AD_F2U;
      prio_rd <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tmr     <= tmr_nxt;
      ad_q    <= ad_nxt;
      prio_rd <= prio_rd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tmr_nxt     = tmr;
    ad_nxt      = ad_q;
    prio_rd_nxt = prio_rd;
    SL_CS_N     = 1'b1;
    SL_RD_N     = 1'b1;
    SL_OE_N     = 1'b1;
    SL_WR_N     = 1'b1;
    SL_PKTEND_N = 1'b1;
    SL_DT_T     = 1'b0;
    SL_DT_O     = '0;
    F2U_RDY     = 1'b0;
    rd_issue    = 1'b0;

    case (state)
      ST_IDLE: begin
        // Priority flips to the opposite direction whenever a burst is granted.
        if (rd_el && (prio_rd || !wr_el)) begin
          state_nxt   = ST_RD_BURST;
          ad_nxt      = AD_U2F;
          cnt_nxt     = '0;
          prio_rd_nxt = 1'b0;
        end else if (wr_el) begin
          state_nxt   = ST_WR_BURST;
          ad_nxt      = AD_F2U;
          cnt_nxt     = '0;
          prio_rd_nxt = 1'b1;
        end
      end

      ST_RD_BURST: begin
        SL_CS_N = 1'b0;
        SL_OE_N = 1'b0;
        if (SL_FLAGC && cnt_ok) begin
          SL_RD_N  = 1'b0;
          rd_issue = 1'b1;
          cnt_nxt  = cnt_inc;
        end else begin
          state_nxt = ST_RD_DRAIN;
          tmr_nxt   = '0;
        end
      end

      ST_RD_DRAIN: begin
        SL_CS_N = 1'b0;
        SL_OE_N = 1'b0;
        if (tmr == DRAIN_END) begin
          state_nxt = ST_TURN;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr_inc;
        end
      end

      ST_TURN: begin
        SL_CS_N = 1'b0;
        if (tmr == TURN_END) begin
          state_nxt = ST_IDLE;
        end else begin
          tmr_nxt = tmr_inc;
        end
      end

      ST_WR_BURST: begin
        SL_CS_N = 1'b0;
        SL_DT_T = 1'b1;
        F2U_RDY = SL_FLAGA & cnt_ok;
        if (F2U_VLD && F2U_RDY) begin
          SL_WR_N     = 1'b0;
          SL_DT_O     = F2U_DAT;
          SL_PKTEND_N = ~F2U_LAST;
          cnt_nxt     = cnt_inc;
          if (F2U_LAST || (cnt_inc == CNT_MAX)) begin
            state_nxt = ST_TURN;
            tmr_nxt   = '0;
          end
        end else begin
          state_nxt = ST_TURN;
          tmr_nxt   = '0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign SL_AD = ad_q;
  assign BUSY  = (state != ST_IDLE);

  gpif2_rd_pipe #(
    .WIDTH_DT (WIDTH_DT),
    .LAT_RD   (LAT_RD)
  ) u_rd_pipe (
    .SYS_CLK  (SYS_CLK),
    .SYS_RST  (SYS_RST),
    .rd_issue (rd_issue),
    .dt_i     (SL_DT_I),
    .u2f_dat  (U2F_DAT),
    .u2f_vld  (U2F_VLD)
  );

endmodule
